// File: rtl/ternary_cmp_seq.sv
// ternary_cmp_seq: sequential balanced-ternary magnitude comparator with min/max select and early exit
module ternary_cmp_seq #(
  parameter int TRITS      = 3,
  parameter int TPC        = 1,
  parameter int EARLY_EXIT = 0
) (
  input  logic               I_clk,
  input  logic               I_rst,
  input  logic               I_valid,
  output logic               O_ready,
  input  logic [2*TRITS-1:0] I_a,
  input  logic [2*TRITS-1:0] I_b,
  input  logic [1:0]         I_mode,
  output logic               O_valid,
  input  logic               I_ready,
  output logic [1:0]         O_res,
  output logic [2*TRITS-1:0] O_sel,
  output logic               O_err
);
  localparam int C  = TRITS / TPC;
  localparam int IW = (C > 1) ? $clog2(C) : 1;
  localparam int CW = 2 * TPC;
  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
  state_t             state_q, state_d;
  logic [2*TRITS-1:0] a_q, b_q, sel_d;
  logic [1:0]         mode_q, c_res, res_d;
  logic [IW-1:0]      idx_q;
  logic               dec_q, c_err, c_dec, scan_end;
  logic [CW-1:0]      ca, cb;
  // Ordering -1 < 0 < +1 mapped onto an unsigned rank so trits compare directly.
  function automatic logic [1:0] rank(input logic [1:0] t);
    return (t == 2'b01) ? 2'd2 : (t == 2'b00) ? 2'd1 : 2'd0;
  endfunction
  assign ca = a_q[idx_q*CW +: CW];
  assign cb = b_q[idx_q*CW +: CW];
  // Evaluate the current chunk MS trit first: error anywhere, first differing pair decides.
  always_comb begin
    c_err = 1'b0;
    c_dec = 1'b0;
    c_res = 2'b00;
    for (int j = TPC - 1; j >= 0; j--) begin
      c_err = c_err | (&ca[2*j +: 2]) | (&cb[2*j +: 2]);
      if (!c_dec && ca[2*j +: 2] != cb[2*j +: 2]) begin
        c_dec = 1'b1;
        c_res = (rank(ca[2*j +: 2]) > rank(cb[2*j +: 2])) ? 2'b01 : 2'b10;
      end
    end
  end
  // Running result: an error overrides everything, an earlier decision is never replaced.
  always_comb begin
    res_d    = c_err ? 2'b11 : dec_q ? O_res : c_dec ? c_res : 2'b00;
    sel_d    = c_err ? '0
             : (mode_q == 2'b01) ? ((res_d == 2'b01) ? b_q : a_q)
             : (mode_q == 2'b10) ? ((res_d == 2'b10) ? b_q : a_q)
             : a_q;
    scan_end = c_err | ((EARLY_EXIT != 0) & (dec_q | c_dec)) | (idx_q == '0);
  end
  // Next-state logic for the IDLE -> SCAN -> DONE handshake sequence.
  always_comb begin
    state_d = state_q;
    state_d = (state_q == IDLE) ? (I_valid ? SCAN : IDLE)
            : (state_q == SCAN) ? (scan_end ? DONE : SCAN)
            : (I_ready ? IDLE : DONE);
  end
  // State register; reset drops any transaction in flight.
  always_ff @(posedge I_clk or negedge I_rst) begin
    if (!I_rst) state_q <= IDLE;
    else        state_q <= state_d;
  end
  // Operand capture on accept, then per-chunk result accumulation while scanning.
  always_ff @(posedge I_clk or negedge I_rst) begin
    if (!I_rst) begin
      a_q    <= '0;
      b_q    <= '0;
      mode_q <= '0;
      idx_q  <= '0;
      dec_q  <= 1'b0;
      O_res  <= '0;
      O_sel  <= '0;
      O_err  <= 1'b0;
    end else if (state_q == IDLE && I_valid) begin
      a_q    <= I_a;
      b_q    <= I_b;
      mode_q <= I_mode;
      idx_q  <= IW'(C - 1);
      dec_q  <= 1'b0;
      O_res  <= '0;
      O_sel  <= '0;
      O_err  <= 1'b0;
    end else if (state_q == SCAN) begin
      O_res  <= res_d;
      O_sel  <= sel_d;
      O_err  <= c_err;
      dec_q  <= dec_q | c_dec;
      idx_q  <= idx_q - 1'b1;
    end
  end
  assign O_ready = I_rst & (state_q == IDLE);
  assign O_valid = (state_q == DONE);
endmodule

// File: tb/tb_ternary_cmp_seq.sv
// tb_ternary_cmp_seq: directed and random checks of three comparator configurations against a trit-level model
module tb_ternary_cmp_seq;
  typedef struct {
    logic [1:0] res;
    logic [5:0] sel;
    logic       err;
    int         lat;
  } exp_t;
  logic       clk = 1'b0, rst_n = 1'b0, valid = 1'b0, ready = 1'b1;
  logic [5:0] a = '0, b = '0;
  logic [1:0] mode = '0;
  logic       o_v[3], o_r[3], o_e[3];
  logic [1:0] o_res[3];
  logic [5:0] o_sel[3];
  int         checks = 0, failures = 0;
  int         tpc_p[3] = '{1, 1, 3};
  bit         ee_p[3]  = '{0, 1, 0};
  exp_t       q0[$], q1[$], q2[$];
  always #5 clk = ~clk;
  ternary_cmp_seq #(.TRITS(3), .TPC(1), .EARLY_EXIT(0)) u0 (
    .I_clk(clk), .I_rst(rst_n), .I_valid(valid), .O_ready(o_r[0]), .I_a(a), .I_b(b), .I_mode(mode),
    .O_valid(o_v[0]), .I_ready(ready), .O_res(o_res[0]), .O_sel(o_sel[0]), .O_err(o_e[0]));
  ternary_cmp_seq #(.TRITS(3), .TPC(1), .EARLY_EXIT(1)) u1 (
    .I_clk(clk), .I_rst(rst_n), .I_valid(valid), .O_ready(o_r[1]), .I_a(a), .I_b(b), .I_mode(mode),
    .O_valid(o_v[1]), .I_ready(ready), .O_res(o_res[1]), .O_sel(o_sel[1]), .O_err(o_e[1]));
  ternary_cmp_seq #(.TRITS(3), .TPC(3), .EARLY_EXIT(0)) u2 (
    .I_clk(clk), .I_rst(rst_n), .I_valid(valid), .O_ready(o_r[2]), .I_a(a), .I_b(b), .I_mode(mode),
    .O_valid(o_v[2]), .I_ready(ready), .O_res(o_res[2]), .O_sel(o_sel[2]), .O_err(o_e[2]));
  task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s dut%0d observed=%0h expected=%0h", tag, k, obs, exp);
    end
  endtask
  function automatic logic [1:0] rank(input logic [1:0] t);
    return (t == 2'b01) ? 2'd2 : (t == 2'b00) ? 2'd1 : 2'd0;
  endfunction
  function automatic exp_t model(input logic [5:0] x, input logic [5:0] y, input logic [1:0] m,
                                 input int tpc, input bit ee);
    exp_t e;
    int nc, i;
    bit dec, stop;
    logic [1:0] ta, tb;
    nc = 3 / tpc;
    e.res = 2'b00; e.err = 1'b0; e.lat = nc; dec = 0; stop = 0;
    for (int c = nc - 1; c >= 0 && !stop; c--) begin
      for (int t = 0; t < tpc; t++) begin
        i = c * tpc + t;
        if (x[2*i +: 2] == 2'b11 || y[2*i +: 2] == 2'b11) e.err = 1'b1;
      end
      if (e.err) begin
        e.res = 2'b11; e.lat = nc - c; stop = 1;
      end else begin
        for (int t = tpc - 1; t >= 0; t--) begin
          i = c * tpc + t;
          ta = x[2*i +: 2]; tb = y[2*i +: 2];
          if (!dec && ta != tb) begin
            dec = 1;
            e.res = (rank(ta) > rank(tb)) ? 2'b01 : 2'b10;
          end
        end
        if (dec && ee) begin e.lat = nc - c; stop = 1; end
      end
    end
    e.sel = e.err ? 6'd0 : (m == 2'b01) ? ((e.res == 2'b01) ? y : x)
          : (m == 2'b10) ? ((e.res == 2'b10) ? y : x) : x;
    return e;
  endfunction
  function automatic exp_t pop(input int k);
    exp_t e;
    if (k == 0) e = q0.pop_front();
    else if (k == 1) e = q1.pop_front();
    else e = q2.pop_front();
    return e;
  endfunction
  task automatic run(input logic [5:0] x, input logic [5:0] y, input logic [1:0] m, input int hold);
    exp_t cur[3];
    bit seen[3];
    int k;
    @(negedge clk);
    for (int i = 0; i < 3; i++) chk("ready_idle", i, 32'(o_r[i]), 1);
    a = x; b = y; mode = m; valid = 1'b1; ready = (hold == 0);
    q0.push_back(model(x, y, m, tpc_p[0], ee_p[0]));
    q1.push_back(model(x, y, m, tpc_p[1], ee_p[1]));
    q2.push_back(model(x, y, m, tpc_p[2], ee_p[2]));
    @(posedge clk);
    #1 valid = 1'b0; a = ~x; b = ~y; mode = ~m;
    for (int i = 0; i < 3; i++) seen[i] = 0;
    k = 0;
    while (!(seen[0] && seen[1] && seen[2]) && k <= 8) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        if (!seen[i] && o_v[i]) begin
          seen[i] = 1;
          cur[i] = pop(i);
          chk("res", i, 32'(o_res[i]), 32'(cur[i].res));
          chk("sel", i, 32'(o_sel[i]), 32'(cur[i].sel));
          chk("err", i, 32'(o_e[i]), 32'(cur[i].err));
          chk("latency", i, k, cur[i].lat);
        end
      end
      k++;
    end
    for (int i = 0; i < 3; i++) if (!seen[i]) begin
      chk("valid_timeout", i, 32'(o_v[i]), 1);
      cur[i] = pop(i);
    end
    if (hold > 0) begin
      for (int h = 0; h < hold; h++) begin
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
          chk("hold_valid", i, 32'(o_v[i]), 1);
          chk("hold_ready", i, 32'(o_r[i]), 0);
          chk("hold_res", i, 32'(o_res[i]), 32'(cur[i].res));
          chk("hold_sel", i, 32'(o_sel[i]), 32'(cur[i].sel));
          chk("hold_err", i, 32'(o_e[i]), 32'(cur[i].err));
        end
      end
      ready = 1'b1;
    end
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk("release_valid", i, 32'(o_v[i]), 0);
      chk("release_ready", i, 32'(o_r[i]), 1);
    end
    ready = 1'b1;
  endtask
  initial begin
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk("rst_valid", i, 32'(o_v[i]), 0);
      chk("rst_ready", i, 32'(o_r[i]), 0);
      chk("rst_res", i, 32'(o_res[i]), 0);
      chk("rst_sel", i, 32'(o_sel[i]), 0);
      chk("rst_err", i, 32'(o_e[i]), 0);
    end
    rst_n = 1'b1;
    run(6'b000010, 6'b000001, 2'b00, 0);
    run(6'b010000, 6'b000000, 2'b10, 0);
    run(6'b011000, 6'b011000, 2'b01, 0);
    run(6'b100000, 6'b000001, 2'b01, 0);
    run(6'b001100, 6'b000000, 2'b00, 0);
    run(6'b010011, 6'b000000, 2'b11, 0);
    run(6'b000001, 6'b000010, 2'b10, 5);
    run(6'b100101, 6'b100110, 2'b10, 0);
    @(negedge clk);
    a = 6'b000010; b = 6'b000001; mode = 2'b00; valid = 1'b1;
    @(posedge clk);
    #1 valid = 1'b0;
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("midscan_rst_valid", i, 32'(o_v[i]), 0);
      chk("midscan_rst_ready", i, 32'(o_r[i]), 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    run(6'b000010, 6'b000001, 2'b00, 0);
    for (int r = 0; r < 8; r++) run(6'($urandom), 6'($urandom), 2'($urandom), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
